// File: rtl/fcore_istore_pkg.sv
// rtl/fcore_istore_pkg.sv - shared loader state type and bank-index width helper
package fcore_istore_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } ld_state_e;

  function automatic int bank_idx_w(input int n_banks);
    return (n_banks > 1) ? $clog2(n_banks) : 1;
  endfunction

endpackage

// File: rtl/fcore_istore_banked_if.sv
// rtl/fcore_istore_banked_if.sv - load stream, swap control, fetch and readback signals
interface fcore_istore_banked_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 12,
  parameter int BANK_W     = 1
);
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_valid;
  logic                  load_last;
  logic                  load_ready;
  logic [BANK_W-1:0]     load_bank;
  logic                  load_error;
  logic [ADDR_W:0]       load_length;
  logic                  swap_request;
  logic                  program_boundary;
  logic [BANK_W-1:0]     active_bank;
  logic                  swap_pending;
  logic                  fetch_enable;
  logic [ADDR_W-1:0]     fetch_addr;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  rb_valid;
  logic [BANK_W-1:0]     rb_bank;
  logic [ADDR_W-1:0]     rb_addr;
  logic                  rb_ready;
  logic                  rb_data_valid;
  logic [DATA_WIDTH-1:0] rb_data;

  modport master (
    output load_data, load_valid, load_last, load_bank, swap_request, program_boundary,
           fetch_enable, fetch_addr, rb_valid, rb_bank, rb_addr,
    input  load_ready, load_error, load_length, active_bank, swap_pending, fetch_data,
           rb_ready, rb_data_valid, rb_data
  );

  modport slave (
    input  load_data, load_valid, load_last, load_bank, swap_request, program_boundary,
           fetch_enable, fetch_addr, rb_valid, rb_bank, rb_addr,
    output load_ready, load_error, load_length, active_bank, swap_pending, fetch_data,
           rb_ready, rb_data_valid, rb_data
  );
endinterface

// File: rtl/istore_bank_ram.sv
// rtl/istore_bank_ram.sv - one program bank: simple dual-port RAM, registered read
module istore_bank_ram #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_W     = 12,
  parameter bit    INIT_EN    = 1'b0,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Output register only advances on a read so the last word stays visible.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/fcore_istore_banked.sv
// rtl/fcore_istore_banked.sv - banked instruction store with streaming loader and
// boundary-synchronised bank swap
module fcore_istore_banked
  import fcore_istore_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    MEM_DEPTH  = 4096,
  parameter int    N_BANKS    = 2,
  parameter string INIT_FILE  = "init.mem"
) (
  input logic                  clock,
  input logic                  reset,
  fcore_istore_banked_if.slave bus
);
  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int BANK_W = bank_idx_w(N_BANKS);
  localparam int NB_P2  = 1 << BANK_W;
  localparam logic [NB_P2-1:0] BANK_EXISTS = NB_P2'((1 << N_BANKS) - 1);
  localparam logic [ADDR_W:0]  CNT_ONE     = (ADDR_W+1)'(1);

  ld_state_e             state_q, state_d;
  logic [BANK_W-1:0]     bank_q, bank_d;
  logic [ADDR_W:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [ADDR_W:0]       len_q, len_d;
  logic [BANK_W-1:0]     last_bank_q, last_bank_d;
  logic                  last_ok_q, last_ok_d;
  logic [BANK_W-1:0]     active_q, active_d;
  logic                  swap_q, swap_d;
  logic [NB_P2-1:0]      valid_q, valid_d;
  logic                  fetch_pend_q, fetch_pend_d;
  logic [BANK_W-1:0]     fetch_bank_q, fetch_bank_d;
  logic [DATA_WIDTH-1:0] fetch_hold_q, fetch_hold_d;
  logic                  rb_pend_q, rb_pend_d;
  logic [BANK_W-1:0]     rb_bank_q, rb_bank_d;
  logic                  rb_oob_q, rb_oob_d;
  logic [DATA_WIDTH-1:0] rb_hold_q, rb_hold_d;

  logic                  beat, start, wr_en, swap_ok, armed, kill;
  logic                  rb_ready_w, rb_fire;
  logic [BANK_W-1:0]     wr_bank;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0] fetch_data_w, rb_data_w;
  logic [DATA_WIDTH-1:0] rdata [NB_P2];

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    len_d       = len_q;
    last_bank_d = last_bank_q;
    last_ok_d   = last_ok_q;
    active_d    = active_q;
    swap_d      = swap_q;
    valid_d     = valid_q;
    wr_en       = 1'b0;
    wr_bank     = bank_q;
    wr_addr     = cnt_q[ADDR_W-1:0];
    beat        = bus.load_valid && (state_q != COMMIT);
    start       = beat && (state_q == IDLE);

    unique case (state_q)
      IDLE: if (beat) begin
        bank_d  = bus.load_bank;
        cnt_d   = CNT_ONE;
        err_d   = (bus.load_bank == active_q) || !BANK_EXISTS[bus.load_bank];
        wr_en   = !err_d;
        wr_bank = bus.load_bank;
        wr_addr = '0;
        state_d = bus.load_last ? COMMIT : LOAD;
      end
      LOAD: if (beat) begin
        // Counter saturates at MEM_DEPTH; anything past the end is dropped, never wrapped.
        if (cnt_q[ADDR_W]) err_d = 1'b1;
        else               cnt_d = cnt_q + CNT_ONE;
        wr_en = !err_q && !cnt_q[ADDR_W];
        if (bus.load_last) state_d = COMMIT;
      end
      COMMIT: begin
        if (!err_q) begin
          valid_d[bank_q] = 1'b1;
          last_bank_d     = bank_q;
          last_ok_d       = 1'b1;
          len_d           = cnt_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    swap_ok = bus.swap_request && last_ok_q && valid_q[last_bank_q] && (last_bank_q != active_q);
    armed   = swap_q || swap_ok;
    // Overwriting the armed bank cancels the swap, even on a boundary in the same cycle.
    kill    = start && armed && (bus.load_bank == last_bank_q);
    if (kill) begin
      swap_d               = 1'b0;
      valid_d[last_bank_q] = 1'b0;
    end else if (armed && bus.program_boundary) begin
      active_d = last_bank_q;
      swap_d   = 1'b0;
    end else if (swap_ok) begin
      swap_d = 1'b1;
    end
  end

  assign rb_ready_w   = !(bus.fetch_enable && (bus.rb_bank == active_q));
  assign rb_fire      = bus.rb_valid && rb_ready_w;
  assign fetch_data_w = fetch_pend_q ? rdata[fetch_bank_q] : fetch_hold_q;
  assign rb_data_w    = rb_pend_q ? (rb_oob_q ? '0 : rdata[rb_bank_q]) : rb_hold_q;

  always_comb begin
    fetch_pend_d = bus.fetch_enable;
    fetch_bank_d = active_q;
    fetch_hold_d = fetch_data_w;
    rb_pend_d    = rb_fire;
    rb_bank_d    = bus.rb_bank;
    rb_oob_d     = !BANK_EXISTS[bus.rb_bank];
    rb_hold_d    = rb_data_w;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      bank_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      len_q        <= '0;
      last_bank_q  <= '0;
      last_ok_q    <= 1'b0;
      active_q     <= '0;
      swap_q       <= 1'b0;
      valid_q      <= NB_P2'(1);
      fetch_pend_q <= 1'b0;
      fetch_bank_q <= '0;
      fetch_hold_q <= '0;
      rb_pend_q    <= 1'b0;
      rb_bank_q    <= '0;
      rb_oob_q     <= 1'b0;
      rb_hold_q    <= '0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      len_q        <= len_d;
      last_bank_q  <= last_bank_d;
      last_ok_q    <= last_ok_d;
      active_q     <= active_d;
      swap_q       <= swap_d;
      valid_q      <= valid_d;
      fetch_pend_q <= fetch_pend_d;
      fetch_bank_q <= fetch_bank_d;
      fetch_hold_q <= fetch_hold_d;
      rb_pend_q    <= rb_pend_d;
      rb_bank_q    <= rb_bank_d;
      rb_oob_q     <= rb_oob_d;
      rb_hold_q    <= rb_hold_d;
    end
  end

  // Each bank has a single read port: fetch owns the active bank, readback gets the rest.
  for (genvar i = 0; i < NB_P2; i++) begin : g_bank
    if (i < N_BANKS) begin : g_ram
      logic f_hit, r_hit;
      assign f_hit = bus.fetch_enable && (active_q == BANK_W'(i));
      assign r_hit = rb_fire && (bus.rb_bank == BANK_W'(i));
      istore_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W),
        .INIT_EN    (i == 0),
        .INIT_FILE  (INIT_FILE)
      ) u_ram (
        .clock (clock),
        .we    (wr_en && !reset && (wr_bank == BANK_W'(i))),
        .waddr (wr_addr),
        .wdata (bus.load_data),
        .re    (f_hit || r_hit),
        .raddr (f_hit ? bus.fetch_addr : bus.rb_addr),
        .rdata (rdata[i])
      );
    end else begin : g_none
      assign rdata[i] = '0;
    end
  end

  assign bus.load_ready    = (state_q != COMMIT);
  assign bus.load_error    = err_q;
  assign bus.load_length   = len_q;
  assign bus.active_bank   = active_q;
  assign bus.swap_pending  = swap_q;
  assign bus.fetch_data    = fetch_data_w;
  assign bus.rb_ready      = rb_ready_w;
  assign bus.rb_data_valid = rb_pend_q;
  assign bus.rb_data       = rb_data_w;
endmodule

// File: tb/tb_fcore_istore_banked.sv
// tb/tb_fcore_istore_banked.sv - scoreboard bench for the banked instruction store
module tb_fcore_istore_banked;
  localparam int DW      = 32;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int N_BANKS = 3;
  localparam int BW      = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fcore_istore_banked_if #(.DATA_WIDTH(DW), .ADDR_W(AW), .BANK_W(BW)) bus ();

  fcore_istore_banked #(
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (DEPTH),
    .N_BANKS    (N_BANKS),
    .INIT_FILE  ("")
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: bank contents and swap bookkeeping as the rules describe them.
  logic [DW-1:0] m_mem [0:3][0:DEPTH-1];
  bit            m_valid [0:3];
  int            m_active, m_last, m_len;
  bit            m_last_ok, m_pending;
  logic [DW-1:0] m_fd;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] rq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_active  = 0;
    m_pending = 0;
    m_valid   = '{1'b1, 1'b0, 1'b0, 1'b0};
    m_last    = 0;
    m_last_ok = 0;
    m_len     = 0;
    m_fd      = '0;
    fq.delete();
    rq.delete();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_load_ready",   bus.load_ready, 1);
    chk("rst_active_bank",  bus.active_bank, 0);
    chk("rst_swap_pending", bus.swap_pending, 0);
    chk("rst_load_error",   bus.load_error, 0);
    chk("rst_load_length",  bus.load_length, 0);
    chk("rst_rb_valid",     bus.rb_data_valid, 0);
    chk("rst_fetch_data",   bus.fetch_data, 0);
    chk("rst_rb_data",      bus.rb_data, 0);
  endtask

  task automatic do_load(input int b, input int n, input bit seq, input logic [DW-1:0] base,
                         input int rst_at);
    bit err;
    logic [DW-1:0] d;
    err = (b == m_active);
    if (m_pending && b == m_last) begin
      m_pending  = 0;
      m_valid[b] = 0;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d = seq ? base + DW'(i) : DW'($urandom);
      bus.load_valid = 1'b1;
      bus.load_bank  = BW'(b);
      bus.load_last  = (i == n - 1);
      bus.load_data  = d;
      if (i + 1 == rst_at) rst = 1'b1;
      chk("load_ready_beat", bus.load_ready, 1);
      @(posedge clk);
      if (rst) begin
        m_reset();
        return;
      end
      if (i >= DEPTH) err = 1;
      else if (!err) m_mem[b][i] = d;
      if (i == 0) begin
        #1;
        chk("swap_pending_load_start", bus.swap_pending, m_pending);
      end
    end
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    chk("load_ready_commit", bus.load_ready, 0);
    chk("load_error_commit", bus.load_error, err);
    if (!err) begin
      m_valid[b] = 1;
      m_last     = b;
      m_last_ok  = 1;
      m_len      = n;
    end
    @(negedge clk);
    chk("load_ready_idle", bus.load_ready, 1);
    chk("load_error_idle", bus.load_error, err);
    chk("load_length", bus.load_length, m_len);
  endtask

  task automatic pulse(input bit sr, input bit pb);
    bit ok;
    @(negedge clk);
    bus.swap_request     = sr;
    bus.program_boundary = pb;
    ok = sr && m_last_ok && m_valid[m_last] && (m_last != m_active);
    if (pb && (m_pending || ok)) begin
      m_active  = m_last;
      m_pending = 0;
    end else if (ok) begin
      m_pending = 1;
    end
    @(negedge clk);
    bus.swap_request     = 1'b0;
    bus.program_boundary = 1'b0;
    chk("swap_pending", bus.swap_pending, m_pending);
    chk("active_bank", bus.active_bank, m_active);
  endtask

  task automatic fetch_seq(input int n, input int fixed_a);
    int a;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a = (fixed_a >= 0) ? fixed_a : int'($urandom_range(0, DEPTH - 1));
      bus.fetch_enable = 1'b1;
      bus.fetch_addr   = AW'(a);
      fq.push_back(m_mem[m_active][a]);
      m_fd = m_mem[m_active][a];
    end
    @(negedge clk);
    bus.fetch_enable = 1'b0;
  endtask

  task automatic rb_req(input int b, input int a, input bit fe);
    int  fa;
    bit  rdy;
    @(negedge clk);
    fa = int'($urandom_range(0, DEPTH - 1));
    bus.rb_valid     = 1'b1;
    bus.rb_bank      = BW'(b);
    bus.rb_addr      = AW'(a);
    bus.fetch_enable = fe;
    bus.fetch_addr   = AW'(fa);
    #1;
    rdy = !(fe && b == m_active);
    chk("rb_ready", bus.rb_ready, rdy);
    if (rdy) rq.push_back((b >= N_BANKS) ? '0 : m_mem[b][a]);
    if (fe) begin
      fq.push_back(m_mem[m_active][fa]);
      m_fd = m_mem[m_active][fa];
    end
    @(negedge clk);
    bus.rb_valid     = 1'b0;
    bus.fetch_enable = 1'b0;
  endtask

  initial begin : monitor
    bit f_iss, r_acc;
    forever begin
      @(posedge clk);
      f_iss = bus.fetch_enable && !rst;
      r_acc = bus.rb_valid && bus.rb_ready && !rst;
      #1;
      if (!rst) begin
        if (f_iss) begin
          if (fq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL fetch_scoreboard: fetch issued with no expected word queued");
          end else chk("fetch_data", bus.fetch_data, fq.pop_front());
        end
        if (r_acc || bus.rb_data_valid) chk("rb_data_valid", bus.rb_data_valid, r_acc);
        if (bus.rb_data_valid) begin
          if (rq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rb_scoreboard: rb_data_valid with no expected word queued");
          end else chk("rb_data", bus.rb_data, rq.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load_data = '0; bus.load_valid = 1'b0; bus.load_last = 1'b0; bus.load_bank = '0;
    bus.swap_request = 1'b0; bus.program_boundary = 1'b0;
    bus.fetch_enable = 1'b0; bus.fetch_addr = '0;
    bus.rb_valid = 1'b0; bus.rb_bank = '0; bus.rb_addr = '0;
    m_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;

    pulse(1, 0);

    do_load(1, 16, 1, 32'h100, 0);
    pulse(1, 0);
    pulse(0, 1);
    fetch_seq(1, 5);
    chk("fetch_addr5_bank1", bus.fetch_data, 32'h105);
    fetch_seq(8, -1);

    do_load(0, 16, 0, '0, 0);
    pulse(1, 0);
    pulse(0, 1);
    fetch_seq(6, -1);

    do_load(0, 5, 0, '0, 0);
    pulse(1, 0);
    fetch_seq(6, -1);

    do_load(2, DEPTH + 2, 0, '0, 0);
    pulse(1, 0);

    do_load(2, 10, 0, '0, 0);
    pulse(1, 1);
    fetch_seq(6, -1);

    do_load(1, 8, 0, '0, 0);
    pulse(1, 0);
    do_load(1, 4, 0, '0, 0);
    pulse(0, 1);

    rb_req(m_active, 3, 1);
    rb_req(m_active, 3, 0);
    chk("fetch_hold", bus.fetch_data, m_fd);
    for (int i = 0; i < 24; i++)
      rb_req(int'($urandom_range(0, 3)), int'($urandom_range(0, DEPTH - 1)), 1'($urandom));
    rb_req(3, 7, 0);

    do_load(1, 6, 0, '0, 3);
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    chk_reset_outputs();
    rst = 1'b0;
    fetch_seq(6, -1);
    rb_req(2, 4, 0);
    rb_req(1, 9, 0);
    rb_req(1, 1, 0);
    pulse(1, 0);

    repeat (3) @(negedge clk);
    chk("fetch_queue_drained", fq.size(), 0);
    chk("rb_queue_drained", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fcore_istore_banked.md
FCORE_ISTORE_BANKED -- requirements
Module: fcore_istore_banked

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter MEM_DEPTH, default 4096, words per bank (power of two); ADDR_W = $clog2(MEM_DEPTH).
REQ-003 SHALL have parameter N_BANKS, default 2, program banks (2..8); BANK_W = max(1,$clog2(N_BANKS)).
REQ-004 SHALL have parameter INIT_FILE, default "init.mem", preload image for bank 0.
REQ-005 clock  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 load_data / load_valid / load_last  in  DATA_WIDTH/1/1  program load stream.
REQ-008 load_ready  out  1  loader accepts beat.
REQ-009 load_bank  in  BANK_W  target bank, sampled on first beat of a load.
REQ-010 load_error  out  1  sticky error for current/last load.
REQ-011 load_length  out  ADDR_W+1  beat count of last committed load.
REQ-012 swap_request  in  1  pulse: arm last committed bank for activation.
REQ-013 program_boundary  in  1  core end-of-program strobe.
REQ-014 active_bank / swap_pending  out  BANK_W/1  executing bank; swap armed.
REQ-015 fetch_enable / fetch_addr  in  1/ADDR_W  core fetch request.
REQ-016 fetch_data  out  DATA_WIDTH  fetched word.
REQ-017 rb_valid / rb_bank / rb_addr  in  1/BANK_W/ADDR_W  debug readback request.
REQ-018 rb_ready / rb_data_valid / rb_data  out  1/1/DATA_WIDTH  readback handshake and data.

Function
REQ-019 Loader FSM SHALL have states IDLE, LOAD, COMMIT; beat accepted when load_valid && load_ready.
REQ-020 load_ready SHALL be 1 in IDLE and LOAD, 0 in COMMIT.
REQ-021 First accepted beat in IDLE SHALL capture load_bank, clear load_error, write address 0, go to LOAD (or COMMIT if load_last).
REQ-022 Each subsequent beat SHALL write at counter+1; load_last beat SHALL move to COMMIT.
REQ-023 Beats beyond MEM_DEPTH-1 SHALL be discarded (no wrap) and set load_error; the stream still completes on load_last.
REQ-024 Load targeting active_bank SHALL discard all writes, set load_error, and not mark the bank valid.
REQ-025 COMMIT (one cycle) SHALL, if no error, set bank_valid[bank], record it as last committed bank, update load_length; then IDLE.
REQ-026 A load starting on the bank armed for swap SHALL clear swap_pending and that bank's valid flag.
REQ-027 swap_request SHALL set swap_pending only if a committed, valid, non-active bank exists; otherwise ignored.
REQ-028 program_boundary with swap_pending SHALL update active_bank next cycle and clear swap_pending; swap_request and program_boundary together SHALL swap in that same edge.
REQ-029 Fetch latency SHALL be 1 cycle: fetch_data = bank[active_bank at issue cycle][fetch_addr]; fetch_data holds when fetch_enable low.
REQ-030 rb_ready SHALL be ~(fetch_enable && rb_bank == active_bank); rb_data_valid SHALL pulse 1 cycle after accepted request with rb_data.
REQ-031 rb_bank >= N_BANKS SHALL be accepted and return rb_data = 0.

Reset
REQ-032 Reset SHALL give: FSM IDLE, active_bank 0, swap_pending 0, load_error 0, load_length 0, rb_data_valid 0, fetch_data 0, rb_data 0, bank_valid = only bank 0.
REQ-033 Reset mid-load SHALL abandon the load without marking any bank valid; memory contents are not cleared.

Structure
REQ-034 Shared package fcore_istore_pkg SHALL hold loader state enum and bank-index width function.
REQ-035 One sub-module istore_bank_ram (simple dual-port, 1-cycle read, INIT_FILE option) SHALL be instantiated N_BANKS times via generate.

Verification
REQ-036 Load 16 words 0x100..0x10F to bank 1, swap_request, program_boundary -> active_bank=1 next cycle, fetch addr 5 returns 0x105, load_length=16.
REQ-037 Load to bank 0 while active -> load_error=1, bank 0 fetch unchanged, swap_request ignored.
REQ-038 Stream MEM_DEPTH+2 beats -> load_error=1, bank not valid, load_ready returns 1 after COMMIT.
REQ-039 swap_request then new load to same bank before boundary -> swap_pending=0, active_bank unchanged at boundary.
REQ-040 rb to active bank with fetch_enable=1 -> rb_ready=0; fetch_enable=0 -> accepted, rb_data_valid next cycle, correct data.
REQ-041 Assert reset during LOAD beat 3 -> all outputs at REQ-032 values next cycle; previous bank contents intact.
